lcd_frame_streamer: RTL and testbench

Pixel-pull SPI transmitter for the 132x162 ST7735-class panel: runs the power-on init command sequence, then endlessly streams full frames by driving a pixel address (x, y) to the pixel-source mux and serialising the returned RGB565 word onto the LCD's SPI pins. Sits between the animation/menu pixel sources (address in, data out) and the panel pins; it is the consuming end of the `ram_lcd_addr_*` / `ram_lcd_data` interface.

---
 rtl/lcd_frame_streamer_pkg.sv | 49 ++++
 rtl/lcd_frame_streamer_if.sv | 25 ++
 rtl/lcd_frame_streamer_spi.sv | 60 ++++++
 rtl/lcd_frame_streamer.sv | 182 ++++++++++++++++++
 tb/tb_lcd_frame_streamer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_frame_streamer_pkg.sv
// Shared panel constants: ST7735 opcodes, default geometry, top-state encoding and
// the command ROM that holds the init sequence followed by the per-frame window.
package lcd_pkg;

  localparam int LCD_W_DEF = 132;
  localparam int LCD_H_DEF = 162;

  localparam logic [7:0] OP_SLPOUT = 8'h11;
  localparam logic [7:0] OP_COLMOD = 8'h3A;
  localparam logic [7:0] OP_MADCTL = 8'h36;
  localparam logic [7:0] OP_DISPON = 8'h29;
  localparam logic [7:0] OP_CASET  = 8'h2A;
  localparam logic [7:0] OP_RASET  = 8'h2B;
  localparam logic [7:0] OP_RAMWR  = 8'h2C;

  // ROM layout: 0 SLPOUT, 1..5 init tail, 6..16 window, 17 = end of window
  localparam logic [4:0] ROM_WIN_FIRST = 5'd6;
  localparam logic [4:0] ROM_END       = 5'd17;

  typedef enum logic [2:0] {
    ST_RST_HOLD, ST_RST_WAIT, ST_SLPOUT, ST_SLP_WAIT, ST_INIT, ST_WINDOW, ST_PIXEL
  } lcd_state_e;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } spi_byte_t;

  function automatic spi_byte_t cmd_rom(input logic [4:0] i, input logic [7:0] xmax,
                                        input logic [7:0] ymax);
    spi_byte_t r;
    r = '{1'b1, 8'h00};
    case (i)
      5'd0:  r = '{1'b0, OP_SLPOUT};
      5'd1:  r = '{1'b0, OP_COLMOD};
      5'd2:  r = '{1'b1, 8'h05};
      5'd3:  r = '{1'b0, OP_MADCTL};
      5'd5:  r = '{1'b0, OP_DISPON};
      5'd6:  r = '{1'b0, OP_CASET};
      5'd10: r = '{1'b1, xmax};
      5'd11: r = '{1'b0, OP_RASET};
      5'd15: r = '{1'b1, ymax};
      5'd16: r = '{1'b0, OP_RAMWR};
      default: r = '{1'b1, 8'h00};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lcd_frame_streamer_if.sv
// Pixel-source address/data bus plus the panel pins driven by the frame streamer.
interface lcd_frame_streamer_if;
  logic [15:0] ram_lcd_data;
  logic [7:0]  ram_lcd_addr_x;
  logic [7:0]  ram_lcd_addr_y;
  logic        lcd_rst_n_out;
  logic        lcd_bl_out;
  logic        lcd_dc_out;
  logic        lcd_clk_out;
  logic        lcd_data_out;
  logic        lcd_cs_n_out;
  logic        frame_done;

  modport master (
    input  ram_lcd_data,
    output ram_lcd_addr_x, ram_lcd_addr_y, lcd_rst_n_out, lcd_bl_out, lcd_dc_out,
           lcd_clk_out, lcd_data_out, lcd_cs_n_out, frame_done
  );

  modport slave (
    output ram_lcd_data,
    input  ram_lcd_addr_x, ram_lcd_addr_y, lcd_rst_n_out, lcd_bl_out, lcd_dc_out,
           lcd_clk_out, lcd_data_out, lcd_cs_n_out, frame_done
  );
endinterface

// File: rtl/lcd_frame_streamer_spi.sv
// SPI mode-0 byte shifter: one load cycle, then 8 bits of CLK_DIV low + CLK_DIV high.
// done marks the final high cycle so the next byte can load with no gap.
module lcd_spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       tx_dc,
  output logic       sclk,
  output logic       mosi,
  output logic       dc,
  output logic       busy,
  output logic       done
);
  localparam int CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;

  assign mosi = sh[7];
  assign done = busy && sclk && (cnt == '0) && (bitn == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk <= 1'b0;
      dc   <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
      bitn <= '0;
      sh   <= '0;
    end else if (start && (!busy || done)) begin
      // load cycle counts as one extra low cycle for bit 7
      busy <= 1'b1;
      sh   <= tx_byte;
      dc   <= tx_dc;
      sclk <= 1'b0;
      cnt  <= CW'(CLK_DIV);
      bitn <= '0;
    end else if (busy) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (!sclk) begin
        sclk <= 1'b1;
        cnt  <= CW'(CLK_DIV - 1);
      end else begin
        sclk <= 1'b0;
        if (bitn == 3'd7) begin
          busy <= 1'b0;
        end else begin
          bitn <= bitn + 3'd1;
          sh   <= {sh[6:0], 1'b0};
          cnt  <= CW'(CLK_DIV - 1);
        end
      end
    end
  end
endmodule

// File: rtl/lcd_frame_streamer.sv
// Panel bring-up then endless raster streaming: pulls RGB565 words by (x,y) address
// from the pixel mux and sends them through the SPI byte shifter.
module lcd_frame_streamer
  import lcd_pkg::*;
#(
  parameter int LCD_W        = LCD_W_DEF,
  parameter int LCD_H        = LCD_H_DEF,
  parameter int CLK_DIV      = 2,
  parameter int RST_HOLD_CYC = 1000,
  parameter int WAKE_CYC     = 12_000_000
) (
  input logic                  clk,
  input logic                  rst,
  lcd_frame_streamer_if.master bus
);
  localparam int          STAGES    = 2;
  localparam logic [7:0]  XMAX      = 8'(LCD_W - 1);
  localparam logic [7:0]  YMAX      = 8'(LCD_H - 1);
  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYC - 1);
  localparam logic [31:0] WAKE_LAST = 32'(WAKE_CYC - 1);

  lcd_state_e  state, state_nxt;
  logic [31:0] dly;
  logic [4:0]  idx, idx_nxt;
  logic [7:0]  x, y;
  logic [15:0] pix_word;
  logic        have_word, byte_sel, last_pix;
  logic [STAGES:0] vld_pipe;
  logic        rst_n_q, bl_q, cs_n_q, frame_done_q;

  spi_byte_t   tx_word;
  logic        tx_start, tx_busy, tx_done, start_ok;
  logic        hi_start, lo_start, issue, frame_end, bl_set, at_last;
  logic        sclk, mosi, dc;

  lcd_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (tx_start),
    .tx_byte (tx_word.data),
    .tx_dc   (tx_word.dc),
    .sclk    (sclk),
    .mosi    (mosi),
    .dc      (dc),
    .busy    (tx_busy),
    .done    (tx_done)
  );

  assign start_ok = !tx_busy || tx_done;
  assign at_last  = (x == XMAX) && (y == YMAX);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tx_word   = cmd_rom(idx, XMAX, YMAX);
    tx_start  = 1'b0;
    hi_start  = 1'b0;
    lo_start  = 1'b0;
    issue     = 1'b0;
    frame_end = 1'b0;
    bl_set    = 1'b0;
    case (state)
      ST_RST_HOLD: if (dly == HOLD_LAST) state_nxt = ST_RST_WAIT;
      ST_RST_WAIT: if (dly == WAKE_LAST) state_nxt = ST_SLPOUT;
      ST_SLPOUT: begin
        if (start_ok && idx == 5'd0) begin
          tx_start = 1'b1;
          idx_nxt  = 5'd1;
        end
        if (tx_done) state_nxt = ST_SLP_WAIT;
      end
      ST_SLP_WAIT: if (dly == WAKE_LAST) state_nxt = ST_INIT;
      ST_INIT: begin
        // DISPON completing launches CASET in the same cycle
        if (start_ok) begin
          tx_start = 1'b1;
          idx_nxt  = idx + 5'd1;
        end
        if (tx_done && idx == ROM_WIN_FIRST) begin
          state_nxt = ST_WINDOW;
          bl_set    = 1'b1;
        end
      end
      ST_WINDOW: begin
        if (start_ok && idx != ROM_END) begin
          tx_start = 1'b1;
          idx_nxt  = idx + 5'd1;
        end
        if (tx_done && idx == ROM_END) begin
          state_nxt = ST_PIXEL;
          issue     = 1'b1;
        end
      end
      ST_PIXEL: begin
        if (!byte_sel) begin
          tx_word = '{1'b1, pix_word[15:8]};
          if (have_word && start_ok) begin
            tx_start = 1'b1;
            hi_start = 1'b1;
          end else if (last_pix && tx_done) begin
            frame_end = 1'b1;
            tx_word   = cmd_rom(ROM_WIN_FIRST, XMAX, YMAX);
            tx_start  = 1'b1;
            idx_nxt   = ROM_WIN_FIRST + 5'd1;
            state_nxt = ST_WINDOW;
          end
        end else begin
          tx_word = '{1'b1, pix_word[7:0]};
          if (start_ok) begin
            tx_start = 1'b1;
            lo_start = 1'b1;
            issue    = !at_last;
          end
        end
      end
      default: state_nxt = ST_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_RST_HOLD;
      dly          <= '0;
      idx          <= '0;
      x            <= '0;
      y            <= '0;
      pix_word     <= '0;
      have_word    <= 1'b0;
      byte_sel     <= 1'b0;
      last_pix     <= 1'b0;
      vld_pipe     <= '0;
      rst_n_q      <= 1'b0;
      bl_q         <= 1'b0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      dly      <= (state_nxt != state) ? 32'd0 : dly + 32'd1;
      idx      <= idx_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      if (hi_start) begin
        byte_sel  <= 1'b1;
        have_word <= 1'b0;
      end
      // source answers exactly STAGES cycles after the address moves
      if (vld_pipe[STAGES]) begin
        pix_word  <= bus.ram_lcd_data;
        have_word <= 1'b1;
      end
      if (lo_start) begin
        byte_sel <= 1'b0;
        if (at_last) begin
          last_pix <= 1'b1;
        end else if (x == XMAX) begin
          x <= '0;
          y <= y + 8'd1;
        end else begin
          x <= x + 8'd1;
        end
      end
      if (frame_end) begin
        x        <= '0;
        y        <= '0;
        last_pix <= 1'b0;
      end
      rst_n_q      <= (state_nxt != ST_RST_HOLD);
      cs_n_q       <= (state_nxt inside {ST_RST_HOLD, ST_RST_WAIT, ST_SLP_WAIT});
      if (bl_set) bl_q <= 1'b1;
      frame_done_q <= frame_end;
    end
  end

  assign bus.ram_lcd_addr_x = x;
  assign bus.ram_lcd_addr_y = y;
  assign bus.lcd_rst_n_out  = rst_n_q;
  assign bus.lcd_bl_out     = bl_q;
  assign bus.lcd_dc_out     = dc;
  assign bus.lcd_clk_out    = sclk;
  assign bus.lcd_data_out   = mosi;
  assign bus.lcd_cs_n_out   = cs_n_q;
  assign bus.frame_done     = frame_done_q;
endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Directed bring-up/frame/reset sequence with a random-salted pixel source; SPI bytes
// are decoded from the pins and compared with a byte list built from the panel rules.
module tb_lcd_frame_streamer;
  localparam int W = 132, H = 3, CD = 1, RH = 4, WK = 8;
  localparam int FRAME_BYTES = 11 + 2 * W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_frame_streamer_if bus();
  lcd_frame_streamer #(.LCD_W(W), .LCD_H(H), .CLK_DIV(CD), .RST_HOLD_CYC(RH),
                       .WAKE_CYC(WK)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cmp = 0, bad = 0;
  logic [15:0] salt;

  // pixel source: registered twice, so data answers the address of two cycles ago
  logic [15:0] src_d1, src_d2;
  always @(posedge clk) begin
    src_d1 <= {bus.ram_lcd_addr_y, bus.ram_lcd_addr_x} ^ salt;
    src_d2 <= src_d1;
  end
  assign bus.ram_lcd_data = src_d2;

  function automatic logic [15:0] pix(input int px, input int py);
    return {8'(py), 8'(px)} ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI pin decoder
  int bits = 0, fd_n = 0;
  logic [7:0] sh;
  logic prev_sclk = 1'b0;
  logic [8:0] q[$];
  int fd_at[$];
  always @(negedge clk) begin
    if (!rst) begin
      bits = 0;
      prev_sclk = 1'b0;
    end else begin
      if (bus.lcd_clk_out && !prev_sclk) begin
        chk("cs_low_on_sclk", {31'd0, bus.lcd_cs_n_out}, 32'd0);
        sh = {sh[6:0], bus.lcd_data_out};
        bits++;
        if (bits == 8) begin
          q.push_back({bus.lcd_dc_out, sh});
          bits = 0;
        end
      end
      prev_sclk = bus.lcd_clk_out;
      if (bus.frame_done) begin
        fd_n++;
        fd_at.push_back(q.size());
      end
    end
  end

  logic [8:0] exp_q[$];
  task automatic add_init();
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h3A}); exp_q.push_back({1'b1, 8'h05});
    exp_q.push_back({1'b0, 8'h36}); exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'h29});
  endtask

  task automatic add_frame();
    exp_q.push_back({1'b0, 8'h2A});
    repeat (3) exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'(W - 1)});
    exp_q.push_back({1'b0, 8'h2B});
    repeat (3) exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'(H - 1)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++) begin
        logic [15:0] p;
        p = pix(px, py);
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
      end
  endtask

  task automatic cmp_stream(input string tag, input int from, input int n);
    for (int i = from; i < from + n; i++)
      chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? 32'(q[i]) : 32'hffff_ffff,
          32'(exp_q[i]));
  endtask

  task automatic wait_q(input int n, input int lim, input string tag);
    int c = 0;
    while (q.size() < n && c < lim) begin
      @(posedge clk); #2;
      c++;
    end
    chk({tag, "_bytes"}, {31'd0, q.size() >= n}, 32'd1);
  endtask

  task automatic wait_fd(input int n, input int lim);
    int c = 0;
    while (fd_n < n && c < lim) begin
      @(posedge clk); #2;
      c++;
    end
    chk($sformatf("frame_done_%0d_seen", n), {31'd0, fd_n >= n}, 32'd1);
  endtask

  initial begin
    int n, r, c;
    salt = 16'($urandom);
    add_init();
    add_frame();
    add_frame();

    repeat (10) @(posedge clk);
    #2;
    chk("rst_rst_n", {31'd0, bus.lcd_rst_n_out}, 32'd0);
    chk("rst_bl",    {31'd0, bus.lcd_bl_out},    32'd0);
    chk("rst_dc",    {31'd0, bus.lcd_dc_out},    32'd0);
    chk("rst_sclk",  {31'd0, bus.lcd_clk_out},   32'd0);
    chk("rst_mosi",  {31'd0, bus.lcd_data_out},  32'd0);
    chk("rst_cs_n",  {31'd0, bus.lcd_cs_n_out},  32'd1);
    chk("rst_x",     {24'd0, bus.ram_lcd_addr_x}, 32'd0);
    chk("rst_y",     {24'd0, bus.ram_lcd_addr_y}, 32'd0);
    chk("rst_fd",    {31'd0, bus.frame_done},    32'd0);

    rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!bus.lcd_rst_n_out && n < 100);
    chk("rst_hold_len", n, RH);

    wait_q(1, 300, "slpout");
    repeat (2) @(posedge clk);
    #2;
    chk("cs_high_slp_delay", {31'd0, bus.lcd_cs_n_out}, 32'd1);
    wait_q(5, 300, "init_tail");
    chk("bl_before_dispon", {31'd0, bus.lcd_bl_out}, 32'd0);
    wait_q(6, 300, "dispon");
    chk("bl_after_dispon", {31'd0, bus.lcd_bl_out}, 32'd1);

    wait_fd(1, 20000);
    chk("addr_x_after_frame", {24'd0, bus.ram_lcd_addr_x}, 32'd0);
    chk("addr_y_after_frame", {24'd0, bus.ram_lcd_addr_y}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("fd_single_pulse", fd_n, 1);
    chk("fd1_byte_pos", (fd_at.size() > 0) ? fd_at[0] : -1, 6 + FRAME_BYTES);
    cmp_stream("frame1", 0, 6 + FRAME_BYTES);

    wait_fd(2, 20000);
    repeat (3) @(posedge clk);
    #2;
    chk("fd_count2", fd_n, 2);
    chk("fd2_byte_pos", (fd_at.size() > 1) ? fd_at[1] : -1, 6 + 2 * FRAME_BYTES);
    cmp_stream("frame2", 6 + FRAME_BYTES, FRAME_BYTES);

    // abort in the middle of a pixel byte of the third frame
    r = $urandom_range(4, 60);
    wait_q(6 + 2 * FRAME_BYTES + 11 + r, 5000, "frame3");
    c = 0;
    while (bits != 4 && c < 100) begin
      @(posedge clk); #2;
      c++;
    end
    chk("mid_byte_bit", bits, 4);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("abort_sclk",  {31'd0, bus.lcd_clk_out},   32'd0);
    chk("abort_cs_n",  {31'd0, bus.lcd_cs_n_out},  32'd1);
    chk("abort_rst_n", {31'd0, bus.lcd_rst_n_out}, 32'd0);
    chk("abort_bl",    {31'd0, bus.lcd_bl_out},    32'd0);
    chk("abort_x",     {24'd0, bus.ram_lcd_addr_x}, 32'd0);
    chk("abort_y",     {24'd0, bus.ram_lcd_addr_y}, 32'd0);
    q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    wait_q(6 + 11 + 16, 3000, "replay");
    cmp_stream("replay", 0, 6 + 11 + 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
